qeciphy_tx_64b_to_32b: RTL and testbench
========================================

# qeciphy_tx_64b_to_32b

Transmit-side width converter and framer. It serialises 64-bit words from the TX datapath into a 32-bit stream, low half first, one 32-bit half per clock. After reset or on request it emits a burst of Frame Alignment Words (FAW) so the far-end 32b→64b receiver can find and lock word alignment. Whenever no user word is available at a slot boundary, it fills the slot with FAW. It sits between the TX link layer and the transceiver's 32-bit parallel interface.

## Interface
- ALIGN_WORDS, 16: number of consecutive FAW slots sent in each alignment burst; legal range 1..255.
- clk_i  in  1  transmit word clock at the 32-bit rate; all logic is on this single clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- align_req_i  in  1  one-cycle pulse that requests a new alignment burst.
- s_tdata_i  in  64  user word.
- s_tvalid_i  in  1  s_tdata_i is valid.
- s_tready_o  out  1  block can accept a word; a transfer occurs on a rising edge where s_tvalid_i && s_tready_o.
- tdata_32b_o  out  32  serialised output; bits [31:0] of a word are sent first, then [63:32].
- faw_active_o  out  1  the half currently on tdata_32b_o belongs to a FAW slot.
- align_done_o  out  1  alignment burst is complete and user data is being accepted.

## Operation
- Registers:
  - `phase`: 0 = low half, 1 = high half; toggles every cycle.
  - `out_reg`: 64-bit slot register.
  - `buf`/`buf_valid`: single-entry holding register.
  - `cnt`: burst counter.
  - `align_pend`: sticky request flag.
  - `state`: one-hot FSM.
- Boundary edge: any rising edge where `phase` == 1 before the edge. `out_reg` loads only on boundary edges.
- Data source on a boundary load in DATA: `buf` if `buf_valid`, which clears `buf_valid`; otherwise `FAW_WORD` (idle fill).
- s_tready_o = (state == DATA) && !buf_valid. An accepted word is written to `buf`. An accept on a boundary edge goes to `buf`; it is never bypassed into `out_reg` on that edge.
- FSM transitions (all evaluated on boundary edges only):
  - RESET → ALIGN: load FAW, cnt ← 1.
  - ALIGN, align_pend set: load FAW, cnt ← 1, clear align_pend.
  - ALIGN, cnt < ALIGN_WORDS: load FAW, cnt ← cnt+1.
  - ALIGN, cnt == ALIGN_WORDS: → DATA; load via the DATA rule.
  - DATA, align_pend set: → ALIGN; load FAW, cnt ← 1, clear align_pend. A word held in `buf` is kept and sent after the burst.
  - DATA, otherwise: load via the DATA rule.
- align_req_i sets align_pend on any edge. A request arriving on a boundary edge is taken at the following boundary.
- align_done_o = (state == DATA), registered with the state.
- Output register updates every edge:
  - tdata_32b_o ← phase ? out_reg[63:32] : out_reg[31:0].
  - faw_active_o ← the FAW flag of `out_reg`.
- Counter `cnt` is 8 bits wide and never wraps, because it is reset to 1 on every burst start.

## Timing
- Reset values:
  - tdata_32b_o = 0, s_tready_o = 0, faw_active_o = 0, align_done_o = 0.
  - phase = 1, out_reg = 0, buf_valid = 0, align_pend = 0, state = RESET.
- Reset assertion clears all registers immediately, mid-slot or mid-burst. A buffered word is discarded.
- After release, number edges E0, E1, …:
  - E0 loads the first FAW.
  - FAW low half is on the output after E1; FAW high half after E2.
  - Burst slots load at E0, E2, …, E(2·ALIGN_WORDS−2).
  - DATA is entered at E(2·ALIGN_WORDS).
- Latency from the accept edge to the low half on tdata_32b_o: 2 edges minimum (accept on a non-boundary edge), 3 edges maximum.
- Throughput: one word per 2 cycles sustained. s_tready_o is low for exactly one cycle after each accept.

## Structure
- qeciphy_pkg holds `FAW_WORD` (64-bit constant) and `is_faw()`; both are shared with the RX converter.
- The FSM enum is local to the module.
- No sub-module. The 1-entry buffer and serializer are inline.

## Test plan
- Reset release, s_tvalid_i = 0, ALIGN_WORDS = 16:
  - tdata_32b_o alternates FAW_WORD[31:0] / FAW_WORD[63:32] from E1 onward.
  - align_done_o and s_tready_o rise after E32.
  - faw_active_o = 1 throughout.
- Single word 64'h0123_4567_89AB_CDEF accepted at E33:
  - 32'h89AB_CDEF after E35, then 32'h0123_4567 after E36, with faw_active_o = 0.
  - FAW idle fill resumes afterwards.
- Continuous s_tvalid_i with incrementing data 1, 2, 3, …:
  - Output is gap-free: word n low half, then high half.
  - s_tready_o toggles every cycle; no FAW slots between words.
- align_req_i pulse while a word sits in `buf`:
  - Next boundary starts a 16-slot FAW burst; align_done_o = 0 for 32 cycles.
  - The buffered word is sent immediately after the burst.
- rst_n_i asserted mid-slot with `buf` full:
  - All outputs are 0 immediately.
  - After release the full burst repeats and the buffered word is never emitted.
- Loopback through the RX 32b→64b converter at both clock phase offsets:
  - RX aligned output asserts within the burst.
  - All 1000 random words are recovered in order.

Source files
------------

// File: rtl/qeciphy_pkg.sv
// qeciphy_pkg: constants and helpers shared by the TX and RX width converters.
package qeciphy_pkg;

    localparam logic [63:0] FAW_WORD = 64'hA5C3_3C5A_D2B4_4B2D;

    function automatic logic is_faw(input logic [63:0] w);
        return w == FAW_WORD;
    endfunction

endpackage

// File: rtl/qeciphy_tx_64b_to_32b.sv
// qeciphy_tx_64b_to_32b: serialises 64-bit words into a 32-bit stream, low half first,
// framing with FAW bursts for alignment and FAW idle fill when no word is waiting.
module qeciphy_tx_64b_to_32b
    import qeciphy_pkg::*;
#(
    parameter int ALIGN_WORDS = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        align_req_i,
    input  logic [63:0] s_tdata_i,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    output logic [31:0] tdata_32b_o,
    output logic        faw_active_o,
    output logic        align_done_o
);

    typedef enum logic [2:0] {
        ST_RESET = 3'b001,
        ST_ALIGN = 3'b010,
        ST_DATA  = 3'b100
    } state_t;

    localparam logic [7:0] ALIGN_CNT = 8'(ALIGN_WORDS);

    state_t      state;
    logic        phase;
    logic [63:0] out_reg;
    logic        out_faw;
    logic [63:0] hold;
    logic        hold_valid;
    logic        align_pend;
    logic [7:0]  cnt;

    assign s_tready_o = (state == ST_DATA) && !hold_valid;

    // Slot decisions happen only when phase is 1 before the edge (slot boundary).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_RESET;
            phase        <= 1'b1;
            out_reg      <= '0;
            out_faw      <= 1'b0;
            hold         <= '0;
            hold_valid   <= 1'b0;
            align_pend   <= 1'b0;
            cnt          <= '0;
            tdata_32b_o  <= '0;
            faw_active_o <= 1'b0;
            align_done_o <= 1'b0;
        end else begin
            phase        <= !phase;
            tdata_32b_o  <= phase ? out_reg[63:32] : out_reg[31:0];
            faw_active_o <= out_faw;
            if (s_tvalid_i && s_tready_o) begin
                hold       <= s_tdata_i;
                hold_valid <= 1'b1;
            end
            if (align_req_i)
                align_pend <= 1'b1;
            if (phase) begin
                case (state)
                    ST_RESET: begin
                        state   <= ST_ALIGN;
                        out_reg <= FAW_WORD;
                        out_faw <= 1'b1;
                        cnt     <= 8'd1;
                    end
                    ST_ALIGN: begin
                        if (align_pend) begin
                            out_reg    <= FAW_WORD;
                            out_faw    <= 1'b1;
                            cnt        <= 8'd1;
                            align_pend <= align_req_i;
                        end else if (cnt < ALIGN_CNT) begin
                            out_reg <= FAW_WORD;
                            out_faw <= 1'b1;
                            cnt     <= cnt + 8'd1;
                        end else begin
                            state        <= ST_DATA;
                            align_done_o <= 1'b1;
                            out_reg      <= hold_valid ? hold : FAW_WORD;
                            out_faw      <= !hold_valid;
                            if (hold_valid)
                                hold_valid <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (align_pend) begin
                            state        <= ST_ALIGN;
                            align_done_o <= 1'b0;
                            out_reg      <= FAW_WORD;
                            out_faw      <= 1'b1;
                            cnt          <= 8'd1;
                            align_pend   <= align_req_i;
                        end else begin
                            out_reg <= hold_valid ? hold : FAW_WORD;
                            out_faw <= !hold_valid;
                            if (hold_valid)
                                hold_valid <= 1'b0;
                        end
                    end
                    default: state <= ST_RESET;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qeciphy_tx_64b_to_32b.sv
// tb_qeciphy_tx_64b_to_32b: directed checks of framing, serialisation, realignment and reset.
module tb_qeciphy_tx_64b_to_32b;
    import qeciphy_pkg::*;

    localparam logic [31:0] FAW_LO = FAW_WORD[31:0];
    localparam logic [31:0] FAW_HI = FAW_WORD[63:32];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        align_req;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] tdata_32b;
    logic        faw_active;
    logic        align_done;

    int checks = 0;
    int errors = 0;

    qeciphy_tx_64b_to_32b #(.ALIGN_WORDS(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .align_req_i (align_req),
        .s_tdata_i   (s_tdata),
        .s_tvalid_i  (s_tvalid),
        .s_tready_o  (s_tready),
        .tdata_32b_o (tdata_32b),
        .faw_active_o(faw_active),
        .align_done_o(align_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk(input int n);
        return {32'h5000_0000 | 32'(n), 32'(n)};
    endfunction

    // Checks E0..E32 after a reset release on the preceding falling edge.
    task automatic run_burst();
        @(posedge clk); #1;
        check("e0_tdata", tdata_32b, 0);
        check("e0_faw", faw_active, 0);
        check("e0_done", align_done, 0);
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            check("burst_tdata", tdata_32b, (e % 2) ? FAW_LO : FAW_HI);
            check("burst_faw", faw_active, 1);
            check("burst_done", align_done, e == 32);
            check("burst_tready", s_tready, e == 32);
        end
    endtask

    initial begin
        logic [63:0] w;
        int          n;
        rst_n     = 1'b0;
        align_req = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tdata", tdata_32b, 0);
        check("rst_tready", s_tready, 0);
        check("rst_faw", faw_active, 0);
        check("rst_done", align_done, 0);
        @(negedge clk) rst_n = 1'b1;
        run_burst();
        // Single word accepted at E33.
        s_tvalid = 1'b1;
        s_tdata  = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        check("single_tready_low", s_tready, 0);
        @(posedge clk); #1;
        check("single_tready_back", s_tready, 1);
        check("single_e34_tdata", tdata_32b, FAW_HI);
        @(posedge clk); #1;
        check("single_lo", tdata_32b, 32'h89AB_CDEF);
        check("single_lo_faw", faw_active, 0);
        @(posedge clk); #1;
        check("single_hi", tdata_32b, 32'h0123_4567);
        check("single_hi_faw", faw_active, 0);
        @(posedge clk); #1;
        check("idle_lo", tdata_32b, FAW_LO);
        check("idle_lo_faw", faw_active, 1);
        @(posedge clk); #1;
        check("idle_hi", tdata_32b, FAW_HI);
        // Back-to-back words from E39.
        n        = 1;
        s_tvalid = 1'b1;
        s_tdata  = mk(1);
        for (int e = 39; e <= 52; e++) begin
            @(posedge clk); #1;
            if (e % 2 == 1 && n <= 6) begin
                n++;
                if (n > 6) s_tvalid = 1'b0;
                else s_tdata = mk(n);
            end
            if (e <= 50)
                check("stream_tready", s_tready, e % 2 == 0);
            if (e >= 41) begin
                w = mk((e % 2) ? (e - 39) / 2 : (e - 40) / 2);
                check("stream_tdata", tdata_32b, (e % 2) ? w[31:0] : w[63:32]);
                check("stream_faw", faw_active, 0);
            end
        end
        // Word accepted at E53 together with an alignment request.
        s_tvalid  = 1'b1;
        s_tdata   = 64'hDEAD_BEEF_CAFE_F00D;
        align_req = 1'b1;
        @(posedge clk); #1;
        s_tvalid  = 1'b0;
        align_req = 1'b0;
        check("realign_tready", s_tready, 0);
        check("realign_done_e53", align_done, 1);
        for (int e = 54; e <= 88; e++) begin
            @(posedge clk); #1;
            check("realign_done", align_done, e >= 86);
            if (e <= 86) begin
                check("realign_tdata", tdata_32b, (e % 2) ? FAW_LO : FAW_HI);
                check("realign_faw", faw_active, 1);
            end
        end
        check("realign_word_hi", tdata_32b, 32'hDEAD_BEEF);
        check("realign_word_faw", faw_active, 0);
        // Fill the holding register, then reset mid-slot.
        s_tvalid = 1'b1;
        s_tdata  = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        check("pre_rst_tready", s_tready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tdata", tdata_32b, 0);
        check("async_rst_tready", s_tready, 0);
        check("async_rst_faw", faw_active, 0);
        check("async_rst_done", align_done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_burst();
        for (int e = 33; e <= 36; e++) begin
            @(posedge clk); #1;
            check("post_rst_tdata", tdata_32b, (e % 2) ? FAW_LO : FAW_HI);
            check("post_rst_faw", faw_active, 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
